change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream of the vending FSM's give_change state. Consumes the computed change coin counts (100/50/25 units) and drives three coin hoppers one coin at a time.
- Waits for each hopper's coin-sensed acknowledge and reports progress, completion or a jam fault back to the controller and the display logic.

Parameters:
- COUNT_W, 8, width of each per-denomination coin count.
- PULSE_CYCLES, 4, number of cycles each hopper_fire pulse is held high.
- GAP_CYCLES, 2, idle cycles after an accepted coin before the next fire.
- TIMEOUT_CYCLES, 1000, cycles counted from the start of a fire pulse before a missing ack is declared a jam.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; loads qty_* when the block is idle.
- qty_100  in  COUNT_W  number of 100 coins to dispense.
- qty_50  in  COUNT_W  number of 50 coins to dispense.
- qty_25  in  COUNT_W  number of 25 coins to dispense.
- hopper_ack  in  3  coin-sensed level from each hopper: bit2 = 100, bit1 = 50, bit0 = 25.
- hopper_fire  out  3  one-hot hopper drive, same bit mapping as hopper_ack.
- busy  out  1  high from the cycle after an accepted start until done or fault.
- done  out  1  one-cycle pulse when all requested coins have been dispensed.
- error  out  1  sticky jam flag.
- rem_100, rem_50, rem_25  out  COUNT_W each  coins still owed per denomination.
- dispensed_value  out  16  running total of value paid out in the current job.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE
  - all outputs 0
  - internal counters and the ack-edge history register 0
- States: IDLE, SELECT, FIRE, WAIT_ACK, GAP, DONE, FAULT.
- IDLE:
  - When start=1, latch qty_* into rem_* and clear dispensed_value and error; go to SELECT.
  - start is ignored in every other state except FAULT.
- SELECT (1 cycle): pick the highest non-zero denomination, priority 100 > 50 > 25.
  - If one is non-zero, go to FIRE.
  - If all rem_* are 0, go to DONE.
- FIRE:
  - Exactly one hopper_fire bit is high for PULSE_CYCLES cycles, then go to WAIT_ACK with hopper_fire=0.
  - The timeout counter starts at the first FIRE cycle.
- Ack detection:
  - An ack is a rising edge of the selected hopper_ack bit: current 1, previous-cycle 0.
  - It is accepted in FIRE or WAIT_ACK.
  - If accepted during FIRE, the fire pulse is cut short and the block moves straight to GAP.
  - Edges on non-selected bits are ignored.
- On an accepted ack, in the same cycle:
  - Decrement the selected rem_* by 1.
  - Add the coin value (100, 50 or 25) to dispensed_value.
  - Go to GAP.
- GAP: hold for GAP_CYCLES cycles, then go to SELECT.
- Timeout: if the counter reaches TIMEOUT_CYCLES without an ack, go to FAULT.
  - busy=0 and error=1 in FAULT.
  - rem_* keep the undispensed counts so the controller can report them.
- FAULT: stays until reset or start=1. A start here behaves as in IDLE and clears error.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. rem_* hold 0 and dispensed_value holds the job total until the next start.
- Latency, with start sampled at edge 0:
  - busy=1 from cycle 1.
  - First hopper_fire high from cycle 2.
  - An all-zero job gives done at cycle 2.
- Ack and timeout in the same cycle: the ack wins.
- Reset mid-job aborts immediately and drops hopper_fire within the same cycle.
- dispensed_value is 16 bits, sufficient for 255 × 175 = 44625; there is no saturation logic.

Decomposition:
- Shared package holds:
  - the state enum
  - the coin value constants (25, 50, 100)
  - the hopper bit indices
  - the 16-bit value width constant
- One sub-module, pulse_timer: a loadable down-counter with a terminal flag. Two instances: one for the fire/gap length, one for the timeout.

Test Plan:
- qty 100/50/25 = 1/1/1, each ack raised 3 cycles after its fire starts -> fire order bit2, bit1, bit0; done once; dispensed_value=175; rem_* all 0.
- qty 0/0/0 with start -> busy high for 1 cycle, done at cycle 2, hopper_fire never set.
- qty_25=2, ack held low -> fire on bit0 for 4 cycles; error=1 and busy=0 at cycle 1002; rem_25=2; dispensed_value=0.
- qty_50=2, ack pulsed on bit2 only -> ignored, ends in FAULT; then start with qty_25=1 and a correct ack -> error cleared, done, dispensed_value=25.
- start re-pulsed while busy with qty_100=5 -> ignored; the original job completes with its own counts.
- reset asserted during FIRE -> hopper_fire=0, busy=0 and rem_*=0 asynchronously; the next start runs normally.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared state codes, coin values and hopper bit positions.
package change_dispenser_pkg;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SELECT   = 3'd1;
    localparam logic [2:0] FIRE     = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] FAULT    = 3'd6;
    localparam int VALUE_W = 16;
    localparam logic [VALUE_W-1:0] COIN_100 = 16'd100;
    localparam logic [VALUE_W-1:0] COIN_50  = 16'd50;
    localparam logic [VALUE_W-1:0] COIN_25  = 16'd25;
    localparam int BIT_100 = 2;
    localparam int BIT_50  = 1;
    localparam int BIT_25  = 0;
endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// pulse_timer: loadable saturating down-counter; term is high while the count is zero.
module pulse_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         term
);
    logic [W-1:0] count;
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - W'(1);
    assign term = count == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin at a time over three hoppers, highest value first,
// waiting for each hopper's coin-sensed edge and flagging a jam on timeout.
import change_dispenser_pkg::*;

module change_dispenser #(
    parameter int COUNT_W        = 8,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] qty_100,
    input  logic [COUNT_W-1:0] qty_50,
    input  logic [COUNT_W-1:0] qty_25,
    input  logic [2:0]         hopper_ack,
    output logic [2:0]         hopper_fire,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] rem_100,
    output logic [COUNT_W-1:0] rem_50,
    output logic [COUNT_W-1:0] rem_25,
    output logic [15:0]        dispensed_value
);
    localparam int PW = 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [2:0] state, next, ack_prev, sel;
    logic load_job, accept, fire_term, to_term, fire_load;
    logic [VALUE_W-1:0] coin;
    // sel is derived from rem_*, which only changes on an accepted ack, so it is stable for a whole coin
    always_comb begin
        sel = '0;
        sel[BIT_100] = |rem_100;
        sel[BIT_50]  = ~|rem_100 & |rem_50;
        sel[BIT_25]  = ~|rem_100 & ~|rem_50 & |rem_25;
    end
    assign load_job    = start && (state == IDLE || state == FAULT);
    assign accept      = (state == FIRE || state == WAIT_ACK) && |(hopper_ack & ~ack_prev & sel);
    assign coin        = sel[BIT_100] ? COIN_100 : sel[BIT_50] ? COIN_50 : COIN_25;
    assign fire_load   = (state == SELECT && |sel) || accept;
    assign hopper_fire = state == FIRE ? sel : 3'b000;
    assign busy        = state == SELECT || state == FIRE || state == WAIT_ACK || state == GAP;
    assign done        = state == DONE;
    assign error       = state == FAULT;
    pulse_timer #(.W(PW)) u_fire (
        .clock(clock), .reset(reset), .load(fire_load),
        .value(accept ? PW'(GAP_CYCLES - 1) : PW'(PULSE_CYCLES - 1)), .term(fire_term)
    );
    pulse_timer #(.W(TW)) u_timeout (
        .clock(clock), .reset(reset), .load(state == SELECT),
        .value(TW'(TIMEOUT_CYCLES - 1)), .term(to_term)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE, FAULT: next = start ? SELECT : state;
            SELECT:      next = |sel ? FIRE : DONE;
            FIRE:        next = accept ? GAP : to_term ? FAULT : fire_term ? WAIT_ACK : FIRE;
            WAIT_ACK:    next = accept ? GAP : to_term ? FAULT : WAIT_ACK;
            GAP:         next = fire_term ? SELECT : GAP;
            default:     next = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state           <= IDLE;
            ack_prev        <= '0;
            rem_100         <= '0;
            rem_50          <= '0;
            rem_25          <= '0;
            dispensed_value <= '0;
        end else begin
            state    <= next;
            ack_prev <= hopper_ack;
            if (load_job) begin
                rem_100         <= qty_100;
                rem_50          <= qty_50;
                rem_25          <= qty_25;
                dispensed_value <= '0;
            end else if (accept) begin
                if (sel[BIT_100]) rem_100 <= rem_100 - COUNT_W'(1);
                if (sel[BIT_50])  rem_50  <= rem_50 - COUNT_W'(1);
                if (sel[BIT_25])  rem_25  <= rem_25 - COUNT_W'(1);
                dispensed_value <= dispensed_value + coin;
            end
        end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized jobs checked against a coin-list reference model.
module tb_change_dispenser;
    logic       clock = 0;
    logic       reset = 1;
    logic       start = 0;
    logic [7:0] qty_100 = 0, qty_50 = 0, qty_25 = 0;
    logic [2:0] hopper_ack = 0;
    logic [2:0] hopper_fire;
    logic       busy, done, error;
    logic [7:0] rem_100, rem_50, rem_25;
    logic [15:0] dispensed_value;
    int errors = 0;
    int checks = 0;

    change_dispenser dut (
        .clock(clock), .reset(reset), .start(start),
        .qty_100(qty_100), .qty_50(qty_50), .qty_25(qty_25),
        .hopper_ack(hopper_ack), .hopper_fire(hopper_fire),
        .busy(busy), .done(done), .error(error),
        .rem_100(rem_100), .rem_50(rem_50), .rem_25(rem_25),
        .dispensed_value(dispensed_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: the job is the list of coins owed, paid largest first; each ack pays one coin.
    task automatic run_job(input int q100, input int q50, input int q25, input int delay, input bit poke);
        int left[3];
        int total, paid, n, idx;
        logic [2:0] bitv;
        left[2] = q100; left[1] = q50; left[0] = q25;
        total = 100 * q100 + 50 * q50 + 25 * q25;
        paid = 0;
        @(negedge clock);
        qty_100 = 8'(q100); qty_50 = 8'(q50); qty_25 = 8'(q25); start = 1;
        @(negedge clock);
        start = 0;
        check("busy_c1", busy, 1);
        check("error_c1", error, 0);
        check("fire_c1", hopper_fire, 0);
        for (int k = 0; k < q100 + q50 + q25; k++) begin
            idx = left[2] > 0 ? 2 : left[1] > 0 ? 1 : 0;
            bitv = 3'(1 << idx);
            n = 0;
            do begin
                @(negedge clock);
                start = 0;
                n++;
            end while (hopper_fire == 3'b000 && n < 40);
            if (k == 0) check("first_fire_lat", n, 1);
            check("fire_bit", hopper_fire, bitv);
            repeat (delay) @(negedge clock);
            hopper_ack = bitv;
            @(negedge clock);
            hopper_ack = 0;
            left[idx]--;
            paid += idx == 2 ? 100 : idx == 1 ? 50 : 25;
            check("rem_100", rem_100, left[2]);
            check("rem_50", rem_50, left[1]);
            check("rem_25", rem_25, left[0]);
            check("value_run", dispensed_value, paid);
            if (poke && k == 0) begin
                start = 1;
                qty_100 = 8'd5;
            end
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            start = 0;
            n++;
        end
        start = 0;
        if (q100 + q50 + q25 == 0) check("zero_done_lat", n, 1);
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("value_total", dispensed_value, total);
        check("rem_sum_end", rem_100 + rem_50 + rem_25, 0);
        @(negedge clock);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int fire_cycles, n;
        #12;
        check("rst_fire", hopper_fire, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_value", dispensed_value, 0);
        @(negedge clock);
        reset = 0;

        run_job(1, 1, 1, 3, 0);
        run_job(0, 0, 0, 1, 0);

        // Jam: ack never arrives, fault one cycle after 1000 counted cycles
        @(negedge clock);
        qty_100 = 0; qty_50 = 0; qty_25 = 2; start = 1;
        @(negedge clock);
        start = 0;
        fire_cycles = 0;
        for (int c = 2; c <= 1002; c++) begin
            @(negedge clock);
            if (hopper_fire != 0) begin
                fire_cycles++;
                if (hopper_fire != 3'b001) check("jam_fire_bit", hopper_fire, 3'b001);
            end
            if (c == 1001) begin
                check("jam_busy_1001", busy, 1);
                check("jam_err_1001", error, 0);
            end
        end
        check("jam_pulse_len", fire_cycles, 4);
        check("jam_error", error, 1);
        check("jam_busy", busy, 0);
        check("jam_rem25", rem_25, 2);
        check("jam_value", dispensed_value, 0);

        // Ack on the wrong hopper is ignored and the job jams
        @(negedge clock);
        qty_25 = 0; qty_50 = 2; start = 1;
        @(negedge clock);
        start = 0;
        @(negedge clock);
        check("wrong_fire", hopper_fire, 3'b010);
        hopper_ack = 3'b100;
        @(negedge clock);
        hopper_ack = 0;
        check("wrong_rem100", rem_50, 2);
        n = 0;
        while (!error && n < 1100) begin
            @(negedge clock);
            n++;
        end
        check("wrong_error", error, 1);
        check("wrong_rem50", rem_50, 2);
        check("wrong_value", dispensed_value, 0);
        run_job(0, 0, 1, 2, 0);

        run_job(1, 1, 0, 5, 1);

        // Asynchronous reset in the middle of a fire pulse
        @(negedge clock);
        qty_100 = 2; qty_50 = 0; qty_25 = 0; start = 1;
        @(negedge clock);
        start = 0;
        @(negedge clock);
        check("pre_rst_fire", hopper_fire, 3'b100);
        #2 reset = 1;
        #1;
        check("async_fire", hopper_fire, 0);
        check("async_busy", busy, 0);
        check("async_rem100", rem_100, 0);
        @(negedge clock);
        reset = 0;
        run_job(0, 1, 2, 1, 0);

        for (int i = 0; i < 6; i++)
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 6)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
